axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_pkg.sv | 18 +
 rtl/sram_2p.sv | 31 +++
 rtl/axi_sram_slave.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI response codes and channel FSM encodings shared by the SRAM slave
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

endpackage

// File: rtl/sram_2p.sv
// rtl/sram_2p.sv - synchronous 1R1W word RAM with byte write enables, read-first
module sram_2p #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [31:0]           rd_data_o,
  input  logic [3:0]            wr_be_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rd_data_q;

  // Read and write share one process so a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
    for (int b = 0; b < 4; b++) begin
      if (wr_be_i[b]) begin
        mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 INCR-only slave fronting a word SRAM
// Read and write channels run as independent FSMs sharing one 1R1W RAM.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  rd_state_e             r_state_q, r_state_d;
  logic [3:0]            rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [7:0]            rbeat_q, rbeat_d;
  logic                  r_last_beat;

  wr_state_e             w_state_q, w_state_d;
  logic [3:0]            bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [7:0]            wbeat_q, wbeat_d;
  logic                  werr_q, werr_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_last_beat;
  logic                  wlast_mismatch;

  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [31:0]           ram_rd_data;
  logic [3:0]            ram_wr_be;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{araddr[31:ADDR_WIDTH+2], araddr[1:0],
                              awaddr[31:ADDR_WIDTH+2], awaddr[1:0]};

  assign r_last_beat = (rbeat_q == rlen_q);

  // The RAM is read on the AR handshake and on each beat handshake, so the
  // registered RAM output is the current beat and stays put during a stall.
  always_comb begin
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    raddr_d     = raddr_q;
    rlen_d      = rlen_q;
    rbeat_d     = rbeat_q;
    ram_rd_en   = 1'b0;
    ram_rd_addr = raddr_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rid_d       = arid;
          raddr_d     = araddr[ADDR_WIDTH+1:2];
          rlen_d      = arlen;
          rbeat_d     = 8'd0;
          ram_rd_en   = 1'b1;
          ram_rd_addr = araddr[ADDR_WIDTH+1:2];
          r_state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d     = raddr_q + ADDR_WIDTH'(1);
            rbeat_d     = rbeat_q + 8'd1;
            ram_rd_en   = 1'b1;
            ram_rd_addr = raddr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign w_last_beat    = (wbeat_q == wlen_q);
  assign wlast_mismatch = (wlast != w_last_beat);

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    bresp_d   = bresp_q;
    ram_wr_be = 4'b0000;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          bid_d     = awid;
          waddr_d   = awaddr[ADDR_WIDTH+1:2];
          wlen_d    = awlen;
          wbeat_d   = 8'd0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          ram_wr_be = wstrb;
          werr_d    = werr_q | wlast_mismatch;
          if (w_last_beat) begin
            bresp_d   = (werr_q || wlast_mismatch) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            waddr_d = waddr_q + ADDR_WIDTH'(1);
            wbeat_d = wbeat_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rid_q     <= 4'd0;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rbeat_q   <= 8'd0;
      w_state_q <= W_IDLE;
      bid_q     <= 4'd0;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wbeat_q   <= 8'd0;
      werr_q    <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
    end
  end

  sram_2p #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk       (clk),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data),
    .wr_be_i   (ram_wr_be),
    .wr_addr_i (waddr_q),
    .wr_data_i (wdata)
  );

  // RAM output is not reset, so mask it outside a burst.
  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rlast   = rvalid && r_last_beat;
  assign rid     = rid_q;
  assign rresp   = AXI_RESP_OKAY;
  assign rdata   = rvalid ? ram_rd_data : 32'd0;

  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = bresp_q;

endmodule
